cv32e40p_tmr_fault_manager: RTL and testbench

Supervises a bank of TMR majority voters in the fault-tolerant cv32e40p pipeline. It accumulates per-replica disagreement history in leaky saturating counters and escalates once a replica is persistently faulty: it halts the pipeline and runs a resync handshake for that replica. It latches a sticky fatal condition on an uncorrectable vote, on simultaneous multi-replica failure, or on a handshake timeout.

---
 rtl/cv32e40p_ft_pkg.sv | 26 ++
 rtl/cv32e40p_tmr_err_counter.sv | 29 ++
 rtl/cv32e40p_tmr_fault_manager.sv | 156 +++++++++++++++
 tb/tb_cv32e40p_tmr_fault_manager.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_ft_pkg.sv
// Shared types for the TMR fault-tolerance logic of the cv32e40p pipeline.
package cv32e40p_ft_pkg;

  localparam int N_REPLICAS = 3;

  typedef logic [1:0] replica_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HALT    = 3'd1,
    ST_RESYNC  = 3'd2,
    ST_RECOVER = 3'd3,
    ST_FATAL   = 3'd4
  } tmr_mgr_state_e;

  // One-hot request vector selecting a single replica.
  function automatic logic [N_REPLICAS-1:0] replica_onehot(input replica_idx_t idx);
    logic [N_REPLICAS-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_REPLICAS; i++) begin
      if (idx == replica_idx_t'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/cv32e40p_tmr_err_counter.sv
// Leaky saturating error counter for one replica: counts up to sat, decays by one on dec.
module cv32e40p_tmr_err_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  input  logic [CNT_W-1:0] sat,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Clear wins, then saturating increment, then decrement toward zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      if (cnt < sat) cnt <= cnt + ONE;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/cv32e40p_tmr_fault_manager.sv
// Supervises the TMR voters: tracks per-replica disagreement, runs the
// halt/resync handshake for a persistently faulty replica, and latches fatal.
module cv32e40p_tmr_fault_manager
  import cv32e40p_ft_pkg::*;
#(
  parameter int N_IN         = 1,
  parameter int CNT_W        = 4,
  parameter int THRESH       = 8,
  parameter int DECAY_PERIOD = 1024,
  parameter int TIMEOUT      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN-1:0]       err_corrected_i,
  input  logic [N_IN-1:0]       err_detected_i,
  input  logic [2:0]            mismatch_i,
  input  logic                  halt_ack_i,
  input  logic                  resync_ack_i,
  output logic                  halt_req_o,
  output logic [2:0]            resync_req_o,
  output logic                  fatal_o,
  output logic [3*CNT_W-1:0]    err_cnt_o,
  output logic [31:0]           corr_total_o
);

  localparam int DECAY_W = $clog2(DECAY_PERIOD + 1);
  localparam int WAIT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   THRESH_C   = CNT_W'(THRESH);
  localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_PERIOD - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

  tmr_mgr_state_e          state_q, state_d;
  replica_idx_t            sel_q, sel_d;
  logic [CNT_W-1:0]        cnt [N_REPLICAS];
  logic [N_REPLICAS-1:0]   hit, cnt_inc, cnt_clr;
  logic                    hit_multi, fatal_evt, in_idle, quiet, decay_wrap;
  logic [DECAY_W-1:0]      decay_q;
  logic [WAIT_W-1:0]       wait_q;
  logic [31:0]             corr_q;
  logic                    halt_q, fatal_q;
  logic [2:0]              resync_q;

  // Counter controls: counters only move while idle; decay fires on a quiet wrap.
  always_comb begin
    hit     = '0;
    cnt_clr = '0;
    for (int r = 0; r < N_REPLICAS; r++) begin
      hit[r]     = (cnt[r] == THRESH_C);
      cnt_clr[r] = (state_q == ST_RECOVER) && (sel_q == replica_idx_t'(r));
    end
    in_idle    = (state_q == ST_IDLE);
    quiet      = (mismatch_i == 3'b000);
    cnt_inc    = {N_REPLICAS{in_idle}} & mismatch_i;
    decay_wrap = in_idle && quiet && (decay_q == DECAY_LAST);
    hit_multi  = (hit[0] & hit[1]) | (hit[0] & hit[2]) | (hit[1] & hit[2]);
    fatal_evt  = |(err_detected_i & ~err_corrected_i);
  end

  for (genvar r = 0; r < N_REPLICAS; r++) begin : g_cnt
    cv32e40p_tmr_err_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc[r]),
      .dec   (decay_wrap),
      .clr   (cnt_clr[r]),
      .sat   (THRESH_C),
      .cnt   (cnt[r])
    );
  end

  // Next-state logic: escalation from idle, handshake progress and timeouts.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (fatal_evt || hit_multi) begin
          state_d = ST_FATAL;
        end else if (|hit) begin
          state_d = ST_HALT;
          sel_d   = hit[0] ? 2'd0 : (hit[1] ? 2'd1 : 2'd2);
        end
      end
      ST_HALT: begin
        if (halt_ack_i)               state_d = ST_RESYNC;
        else if (wait_q == WAIT_LAST) state_d = ST_FATAL;
      end
      ST_RESYNC: begin
        if (resync_ack_i)             state_d = ST_RECOVER;
        else if (wait_q == WAIT_LAST) state_d = ST_FATAL;
      end
      ST_RECOVER: state_d = ST_IDLE;
      ST_FATAL:   state_d = ST_FATAL;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State, selected replica and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      halt_q   <= 1'b0;
      resync_q <= '0;
      fatal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      halt_q   <= (state_d == ST_HALT) || (state_d == ST_RESYNC) ||
                  (state_d == ST_RECOVER) || (state_d == ST_FATAL);
      resync_q <= ((state_d == ST_RESYNC) || (state_d == ST_RECOVER)) ?
                  replica_onehot(sel_d) : 3'b000;
      fatal_q  <= (state_d == ST_FATAL);
    end
  end

  // Decay timer: counts quiet idle cycles, restarts on any mismatch or recovery.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decay_q <= '0;
    end else if (state_q == ST_RECOVER) begin
      decay_q <= '0;
    end else if (in_idle) begin
      if (!quiet || decay_wrap) decay_q <= '0;
      else                      decay_q <= decay_q + DECAY_W'(1);
    end
  end

  // Handshake wait counter: restarts on every state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else if ((state_d == state_q) &&
                 ((state_q == ST_HALT) || (state_q == ST_RESYNC))) begin
      wait_q <= wait_q + WAIT_W'(1);
    end else begin
      wait_q <= '0;
    end
  end

  // Saturating count of cycles with any corrected error, frozen once fatal.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corr_q <= '0;
    end else if ((state_q != ST_FATAL) && (|err_corrected_i) && (corr_q != 32'hFFFF_FFFF)) begin
      corr_q <= corr_q + 32'd1;
    end
  end

  assign halt_req_o   = halt_q;
  assign resync_req_o = resync_q;
  assign fatal_o      = fatal_q;
  assign err_cnt_o    = {cnt[2], cnt[1], cnt[0]};
  assign corr_total_o = corr_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// Directed bench for the TMR fault manager: vector table plus multi-cycle sequences.
module tb_cv32e40p_tmr_fault_manager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  err_corrected_i = '0;
  logic [1:0]  err_detected_i = '0;
  logic [2:0]  mismatch_i = '0;
  logic        halt_ack_i = 1'b0;
  logic        resync_ack_i = 1'b0;
  logic        halt_req_o;
  logic [2:0]  resync_req_o;
  logic        fatal_o;
  logic [11:0] err_cnt_o;
  logic [31:0] corr_total_o;

  int checks = 0;
  int errors = 0;

  cv32e40p_tmr_fault_manager #(
    .N_IN(2), .CNT_W(4), .THRESH(8), .DECAY_PERIOD(16), .TIMEOUT(256)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .err_corrected_i (err_corrected_i),
    .err_detected_i  (err_detected_i),
    .mismatch_i      (mismatch_i),
    .halt_ack_i      (halt_ack_i),
    .resync_ack_i    (resync_ack_i),
    .halt_req_o      (halt_req_o),
    .resync_req_o    (resync_req_o),
    .fatal_o         (fatal_o),
    .err_cnt_o       (err_cnt_o),
    .corr_total_o    (corr_total_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  corr;
    logic [1:0]  det;
    logic [2:0]  mm;
    logic        hack;
    logic        rack;
    logic        e_halt;
    logic [2:0]  e_rsy;
    logic        e_fatal;
    logic [11:0] e_cnt;
    logic [31:0] e_corr;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic outs(input string tag, input logic h, input logic [2:0] r,
                      input logic f, input logic [11:0] c);
    chk({tag, ".halt"},   64'(halt_req_o),   64'(h));
    chk({tag, ".resync"}, 64'(resync_req_o), 64'(r));
    chk({tag, ".fatal"},  64'(fatal_o),      64'(f));
    chk({tag, ".cnt"},    64'(err_cnt_o),    64'(c));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    err_corrected_i = '0;
    err_detected_i  = '0;
    mismatch_i      = '0;
    halt_ack_i      = 1'b0;
    resync_ack_i    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic mm_steps(input logic [2:0] m, input int n);
    mismatch_i = m;
    repeat (n) step();
    mismatch_i = '0;
  endtask

  initial begin
    // Persistent fault on replica 2 with halt ack tied high, then resync.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{2'b01, 2'b01, 3'b010, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 12'((i + 1) * 16), 32'(i + 1)};
    tbl[8]  = '{2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 12'h080, 32'd8};
    tbl[9]  = '{2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 12'h080, 32'd8};
    tbl[10] = '{2'b11, 2'b11, 3'b111, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 12'h080, 32'd9};
    tbl[11] = '{2'b00, 2'b00, 3'b000, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 12'h080, 32'd9};
    tbl[12] = '{2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 12'h000, 32'd9};
    tbl[13] = '{2'b00, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 12'h001, 32'd9};

    do_reset();
    outs("reset", 1'b0, 3'b000, 1'b0, 12'h000);
    chk("reset.corr", 64'(corr_total_o), 64'd0);

    for (int i = 0; i < 14; i++) begin
      err_corrected_i = tbl[i].corr;
      err_detected_i  = tbl[i].det;
      mismatch_i      = tbl[i].mm;
      halt_ack_i      = tbl[i].hack;
      resync_ack_i    = tbl[i].rack;
      step();
      outs($sformatf("vec%0d", i), tbl[i].e_halt, tbl[i].e_rsy, tbl[i].e_fatal, tbl[i].e_cnt);
      chk($sformatf("vec%0d.corr", i), 64'(corr_total_o), 64'(tbl[i].e_corr));
    end

    // Decay: three hits on replica 1 leak away one per 16 quiet cycles.
    do_reset();
    mm_steps(3'b001, 3);
    chk("decay.load", 64'(err_cnt_o), 64'h003);
    repeat (15) step();
    chk("decay.q15", 64'(err_cnt_o), 64'h003);
    step();
    chk("decay.q16", 64'(err_cnt_o), 64'h002);
    repeat (32) step();
    chk("decay.q48", 64'(err_cnt_o), 64'h000);
    mm_steps(3'b001, 1);
    repeat (10) step();
    mm_steps(3'b001, 1);
    chk("decay.restart", 64'(err_cnt_o), 64'h002);
    repeat (15) step();
    chk("decay.r15", 64'(err_cnt_o), 64'h002);
    step();
    chk("decay.r16", 64'(err_cnt_o), 64'h001);

    // Uncorrectable vote: sticky fatal, counters and corr total frozen.
    do_reset();
    err_detected_i = 2'b01;
    step();
    outs("uncorr", 1'b1, 3'b000, 1'b1, 12'h000);
    err_detected_i  = 2'b00;
    err_corrected_i = 2'b01;
    mismatch_i      = 3'b001;
    halt_ack_i      = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      chk($sformatf("uncorr.hold%0d", i), 64'(fatal_o), 64'd1);
    end
    outs("uncorr.end", 1'b1, 3'b000, 1'b1, 12'h000);
    chk("uncorr.corr", 64'(corr_total_o), 64'd0);
    do_reset();
    outs("uncorr.rst", 1'b0, 3'b000, 1'b0, 12'h000);

    // Double failure: replicas 1 and 3 saturate together.
    do_reset();
    mm_steps(3'b101, 8);
    outs("dbl.load", 1'b0, 3'b000, 1'b0, 12'h808);
    halt_ack_i   = 1'b1;
    resync_ack_i = 1'b1;
    step();
    outs("dbl.fatal", 1'b1, 3'b000, 1'b1, 12'h808);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("dbl.nors%0d", i), 64'(resync_req_o), 64'd0);
    end

    // Timeout waiting for halt ack.
    do_reset();
    mm_steps(3'b001, 8);
    step();
    outs("tohalt.enter", 1'b1, 3'b000, 1'b0, 12'h008);
    repeat (255) step();
    outs("tohalt.255", 1'b1, 3'b000, 1'b0, 12'h008);
    step();
    outs("tohalt.256", 1'b1, 3'b000, 1'b1, 12'h008);

    // Timeout waiting for resync ack.
    do_reset();
    mm_steps(3'b001, 8);
    halt_ack_i = 1'b1;
    step();
    step();
    outs("torsy.enter", 1'b1, 3'b001, 1'b0, 12'h008);
    halt_ack_i = 1'b0;
    repeat (255) step();
    outs("torsy.255", 1'b1, 3'b001, 1'b0, 12'h008);
    step();
    outs("torsy.256", 1'b1, 3'b000, 1'b1, 12'h008);

    // Reset in the middle of a resync, then a stray ack in idle.
    do_reset();
    mm_steps(3'b100, 8);
    halt_ack_i = 1'b1;
    step();
    step();
    outs("mid.rsy", 1'b1, 3'b100, 1'b0, 12'h800);
    rst_n = 1'b0;
    step();
    outs("mid.rst", 1'b0, 3'b000, 1'b0, 12'h000);
    rst_n        = 1'b1;
    halt_ack_i   = 1'b0;
    resync_ack_i = 1'b1;
    step();
    outs("mid.lateack", 1'b0, 3'b000, 1'b0, 12'h000);
    resync_ack_i = 1'b0;
    step();
    outs("mid.after", 1'b0, 3'b000, 1'b0, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
